// File: rtl/mips_mem_pkg.sv
// Shared MIPS data-memory definitions: MemOp size/sign encoding, access FSM states
// and the natural-alignment rule.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MEM_SZ_BYTE = 2'b00,
    MEM_SZ_HALF = 2'b01,
    MEM_SZ_WORD = 2'b10,
    MEM_SZ_RSVD = 2'b11
  } mem_size_e;

  localparam int unsigned MEMOP_ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } mac_state_e;

  // The reserved size never aligns, so it is reported as an alignment error.
  function automatic logic mem_is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (mem_size_e'(size))
      MEM_SZ_BYTE: ok = 1'b1;
      MEM_SZ_HALF: ok = ~addr_lo[0];
      MEM_SZ_WORD: ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends load data, and merges
// sub-word store data into a word read from memory.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  mem_op_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh_amt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] store_rep;
  logic        zext;

  always_comb begin
    sh_amt    = {byte_off_i, 3'b000};
    shifted   = rdata_i >> sh_amt;
    zext      = mem_op_i[MEMOP_ZEXT_BIT];
    load_data_o = shifted;
    lane_mask = 32'hFFFF_FFFF;
    store_rep = store_data_i;
    case (mem_size_e'(mem_op_i[1:0]))
      MEM_SZ_BYTE: begin
        load_data_o = zext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask   = 32'h0000_00FF << sh_amt;
        store_rep   = {4{store_data_i[7:0]}};
      end
      MEM_SZ_HALF: begin
        // Half accesses are aligned upstream, so the byte shift equals the half-lane shift.
        load_data_o = zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask   = 32'h0000_FFFF << {byte_off_i[1], 4'b0000};
        store_rep   = {2{store_data_i[15:0]}};
      end
      default: begin
        load_data_o = shifted;
        lane_mask   = 32'hFFFF_FFFF;
        store_rep   = store_data_i;
      end
    endcase
    merged_o = (rdata_i & ~lane_mask) | (store_rep & lane_mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: stalls the pipeline while a load,
// word store or sub-word read-modify-write runs against a req/ack memory port.
//
//   state | meaning
//   IDLE  | waiting for an access; misaligned accesses flagged here, halt latched here
//   RD    | read request outstanding (load, or first half of sub-word store)
//   WR    | write request outstanding
//   DONE  | one-cycle completion, pipeline released, LoadValid for loads
module mem_access_ctrl
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteIn,
  input  logic        MemtoRegIn,
  input  logic [2:0]  MemOpIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] StoreDataIn,
  input  logic        HaltIn,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AlignErr,
  output logic        HaltDone,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  mac_state_e  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [29:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        halt_done_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic        store_q;

  logic        access;
  logic        aligned;
  logic        live_access;
  logic        launch;
  logic        word_store;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign access      = MemWriteIn | MemtoRegIn;
  assign aligned     = mem_is_aligned(MemOpIn[1:0], AddrIn[1:0]);
  // Combinational outputs are gated by reset so they read 0 while reset is held.
  assign live_access = reset && (state_q == ST_IDLE) && !halt_done_q && access;
  assign launch      = live_access && aligned;
  assign word_store  = MemWriteIn && (mem_size_e'(MemOpIn[1:0]) == MEM_SZ_WORD);

  assign AlignErr  = live_access && !aligned;
  assign Stall     = launch || (state_q == ST_RD) || (state_q == ST_WR);
  assign LoadData  = load_data_q;
  assign LoadValid = load_valid_q;
  assign HaltDone  = halt_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // During RD of a sub-word store, mem_wdata_q still holds the raw store data.
  mem_lane_align u_lane (
    .mem_op_i     (op_q),
    .byte_off_i   (off_q),
    .rdata_i      (mem_rdata),
    .store_data_i (mem_wdata_q),
    .load_data_o  (lane_load),
    .merged_o     (lane_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      halt_done_q  <= 1'b0;
      op_q         <= '0;
      off_q        <= '0;
      store_q      <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (HaltIn && !access) begin
            halt_done_q <= 1'b1;
          end
          if (launch) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= AddrIn[31:2];
            mem_wdata_q <= StoreDataIn;
            op_q        <= MemOpIn;
            off_q       <= AddrIn[1:0];
            store_q     <= MemWriteIn;
            if (word_store) begin
              mem_we_q <= 1'b1;
              state_q  <= ST_WR;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            if (store_q) begin
              mem_wdata_q <= lane_merged;
              mem_we_q    <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              load_data_q  <= lane_load;
              load_valid_q <= 1'b1;
              mem_req_q    <= 1'b0;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected memory
// transactions and load results; a monitor compares them as the DUT produces them.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWriteIn = 1'b0;
  logic        MemtoRegIn = 1'b0;
  logic [2:0]  MemOpIn = 3'b000;
  logic [31:0] AddrIn = '0;
  logic [31:0] StoreDataIn = '0;
  logic        HaltIn = 1'b0;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        AlignErr;
  logic        HaltDone;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .MemWriteIn  (MemWriteIn),
    .MemtoRegIn  (MemtoRegIn),
    .MemOpIn     (MemOpIn),
    .AddrIn      (AddrIn),
    .StoreDataIn (StoreDataIn),
    .HaltIn      (HaltIn),
    .Stall       (Stall),
    .LoadData    (LoadData),
    .LoadValid   (LoadValid),
    .AlignErr    (AlignErr),
    .HaltDone    (HaltDone),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_txn_q[$];
  logic [31:0] exp_load_q[$];
  txn_t        mon_t;
  logic [31:0] mon_ld;

  int n_checks = 0;
  int n_err    = 0;

  int          resp_lat = 0;
  int          resp_cnt = 0;
  logic [31:0] resp_rdata = '0;
  logic        force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: ack arrives resp_lat cycles after each request phase begins.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        resp_cnt = 0;
      end
      if (force_ack) begin
        mem_ack   = 1'b1;
        force_ack = 1'b0;
      end else if (mem_req) begin
        if (resp_cnt == resp_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_rdata;
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Monitor: every completed memory transaction and every LoadValid pops the scoreboard.
  always @(negedge clk) begin
    if (reset && mem_req && mem_ack) begin
      if (exp_txn_q.size() == 0) begin
        chk("txn_unexpected_count", 32'd1, 32'd0);
      end else begin
        mon_t = exp_txn_q.pop_front();
        chk("txn_we", {31'd0, mem_we}, {31'd0, mon_t.we});
        chk("txn_addr", {2'b00, mem_addr}, {2'b00, mon_t.addr});
        if (mon_t.we) chk("txn_wdata", mem_wdata, mon_t.wdata);
      end
    end
    if (LoadValid) begin
      if (exp_load_q.size() == 0) begin
        chk("loadvalid_unexpected", 32'd1, 32'd0);
      end else begin
        mon_ld = exp_load_q.pop_front();
        chk("load_data", LoadData, mon_ld);
      end
    end
  end

  // Drives one aligned access, holds it while stalled, and checks the stall length.
  task automatic run_access(input string name, input logic we, input logic ld,
                            input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] rdv,
                            input int lat, input int exp_stall);
    int  stall_cnt;
    bit  done;
    stall_cnt = 0;
    done = 0;
    @(posedge clk);
    #1;
    resp_lat    = lat;
    resp_rdata  = rdv;
    MemWriteIn  = we;
    MemtoRegIn  = ld;
    MemOpIn     = op;
    AddrIn      = addr;
    StoreDataIn = sdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (Stall) stall_cnt++;
      else done = 1;
    end
    if (!done) chk({name, "_timeout"}, 32'd1, 32'd0);
    chk({name, "_stall_cycles"}, stall_cnt, exp_stall);
    @(posedge clk);
    #1;
    MemWriteIn = 1'b0;
    MemtoRegIn = 1'b0;
  endtask

  task automatic load(input string name, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] rdv, input int lat, input logic [31:0] exp_data);
    exp_txn_q.push_back('{we: 1'b0, addr: addr[31:2], wdata: 32'h0});
    exp_load_q.push_back(exp_data);
    run_access(name, 1'b0, 1'b1, op, addr, 32'h5A5A_5A5A, rdv, lat, lat + 2);
  endtask

  task automatic store(input string name, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdv, input int lat,
                       input logic [31:0] exp_word);
    bit rmw;
    rmw = (op[1:0] != 2'b10);
    if (rmw) exp_txn_q.push_back('{we: 1'b0, addr: addr[31:2], wdata: 32'h0});
    exp_txn_q.push_back('{we: 1'b1, addr: addr[31:2], wdata: exp_word});
    run_access(name, 1'b1, 1'b0, op, addr, sdata, rdv, lat, rmw ? 2 * lat + 3 : lat + 2);
  endtask

  task automatic misaligned(input string name, input logic we, input logic [2:0] op,
                            input logic [31:0] addr);
    @(posedge clk);
    #1;
    MemWriteIn = we;
    MemtoRegIn = ~we;
    MemOpIn    = op;
    AddrIn     = addr;
    @(negedge clk);
    chk({name, "_alignerr"}, {31'd0, AlignErr}, 32'd1);
    chk({name, "_stall"}, {31'd0, Stall}, 32'd0);
    chk({name, "_req"}, {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    MemWriteIn = 1'b0;
    MemtoRegIn = 1'b0;
    @(negedge clk);
    chk({name, "_alignerr_clear"}, {31'd0, AlignErr}, 32'd0);
    chk({name, "_req_after"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_loadvalid", {31'd0, LoadValid}, 32'd0);
    chk("rst_alignerr", {31'd0, AlignErr}, 32'd0);
    chk("rst_haltdone", {31'd0, HaltDone}, 32'd0);
    chk("rst_loaddata", LoadData, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    load("lb_0x103", 3'b000, 32'h0000_0103, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    load("lhu_0x102", 3'b101, 32'h0000_0102, 32'h8001_1234, 1, 32'h0000_8001);
    load("lh_0x102", 3'b001, 32'h0000_0102, 32'h8001_1234, 0, 32'hFFFF_8001);
    load("lbu_0x100", 3'b100, 32'h0000_0100, 32'h0000_00F0, 1, 32'h0000_00F0);
    load("lh_0x100", 3'b001, 32'h0000_0100, 32'h0000_7FFF, 1, 32'h0000_7FFF);
    load("lw_0x104", 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);

    store("sb_0x201", 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h1122_3344, 1, 32'h1122_AB44);
    store("sh_0x202", 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h1122_3344, 1, 32'hBEEF_3344);
    store("sw_0x300", 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1, 32'hDEAD_BEEF);
    chk("loaddata_hold", LoadData, 32'hCAFE_F00D);

    misaligned("sh_0x301", 1'b1, 3'b001, 32'h0000_0301);
    misaligned("lw_0x302", 1'b0, 3'b010, 32'h0000_0302);
    misaligned("rsvd_0x0", 1'b0, 3'b011, 32'h0000_0000);

    // Reset during WR: no memory ack ever arrives for this store.
    @(posedge clk);
    #1;
    resp_lat    = 1000;
    MemWriteIn  = 1'b1;
    MemOpIn     = 3'b010;
    AddrIn      = 32'h0000_0400;
    StoreDataIn = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    chk("wr_req_before_rst", {31'd0, mem_req}, 32'd1);
    chk("wr_we_before_rst", {31'd0, mem_we}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_wr_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rst_wr_we_drop", {31'd0, mem_we}, 32'd0);
    chk("rst_wr_stall", {31'd0, Stall}, 32'd0);
    MemWriteIn = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack_req", {31'd0, mem_req}, 32'd0);
      chk("late_ack_loadvalid", {31'd0, LoadValid}, 32'd0);
    end

    // Halt with no access, then a load that must be ignored.
    @(posedge clk);
    #1;
    HaltIn = 1'b1;
    @(negedge clk);
    chk("halt_before_edge", {31'd0, HaltDone}, 32'd0);
    @(posedge clk);
    #1;
    HaltIn = 1'b0;
    chk("halt_after_edge", {31'd0, HaltDone}, 32'd1);
    resp_lat   = 0;
    MemtoRegIn = 1'b1;
    MemOpIn    = 3'b010;
    AddrIn     = 32'h0000_0500;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halted_req", {31'd0, mem_req}, 32'd0);
      chk("halted_stall", {31'd0, Stall}, 32'd0);
    end
    chk("halt_sticky", {31'd0, HaltDone}, 32'd1);
    MemtoRegIn = 1'b0;

    repeat (3) @(negedge clk);
    chk("txn_queue_empty", exp_txn_q.size(), 32'd0);
    chk("load_queue_empty", exp_load_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
